// File: rtl/config_uart_pkg.sv
// Shared types and constants for the serial configuration front end.
// Used by the byte receiver and the word packer.
package config_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, mid-bit sampling FSM.
// Strobes are decoded from the registered sample point.
module uart_rx_byte
    import config_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       start_seen,
    output logic       rx_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    logic          rx_m;
    logic          rx_s;
    logic          rx_d;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          tick;

    assign tick       = (cnt == '0);
    assign start_seen = (state == RX_IDLE) && rx_d && !rx_s;
    assign byte_valid = (state == RX_STOP) && tick && rx_s;
    assign frame_err  = (state == RX_STOP) && tick && !rx_s;
    assign rx_idle    = (state == RX_IDLE);
    assign byte_data  = shreg;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= Rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                RX_IDLE: begin
                    if (start_seen) begin
                        state <= RX_START;
                        cnt   <= HALF;
                    end
                end
                RX_START: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else if (!rx_s) begin
                        state   <= RX_DATA;
                        cnt     <= FULL;
                        bit_idx <= '0;
                    end else begin
                        // line went high again: a glitch, not a start bit
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (!tick) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (!tick)
                        cnt <= cnt - 1'b1;
                    else
                        state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/config_uart_rx.sv
// Serial config front end: packs received bytes big-endian into words
// and maintains the session-active flag that resets the config FSM.
module config_uart_rx
    import config_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Rx,
    output logic [WORD_WIDTH-1:0] WriteData,
    output logic                  WriteStrobe,
    output logic                  ComActive,
    output logic                  ErrorFrame
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TMO  = IW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    LAST = 2'(BYTES_PER_WORD - 1);

    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  frame_err;
    logic                  start_seen;
    logic                  rx_idle;
    logic [1:0]            byte_cnt;
    logic [WORD_WIDTH-9:0] stage;
    logic [IW-1:0]         idle_cnt;
    logic                  timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .Reset     (Reset),
        .Rx        (Rx),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .start_seen(start_seen),
        .rx_idle   (rx_idle)
    );

    assign timeout = rx_idle && (idle_cnt == TMO);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            idle_cnt <= '0;
        else if (start_seen)
            idle_cnt <= '0;
        else if (idle_cnt != TMO)
            idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            WriteData   <= '0;
            WriteStrobe <= 1'b0;
            ComActive   <= 1'b0;
            ErrorFrame  <= 1'b0;
            byte_cnt    <= '0;
            stage       <= '0;
        end else begin
            WriteStrobe <= 1'b0;
            ErrorFrame  <= frame_err;
            if (frame_err) begin
                byte_cnt <= '0;
            end else if (byte_valid) begin
                ComActive <= 1'b1;
                if (byte_cnt == LAST) begin
                    WriteData   <= {stage, byte_data};
                    WriteStrobe <= 1'b1;
                    byte_cnt    <= '0;
                end else begin
                    stage    <= {stage[WORD_WIDTH-17:0], byte_data};
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (timeout) begin
                // session over: drop any partial word
                ComActive <= 1'b0;
                byte_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_config_uart_rx.sv
// Scoreboard bench for config_uart_rx: words queued at send time,
// popped and compared on every WriteStrobe.
module tb_config_uart_rx;
    import config_uart_pkg::*;

    localparam int CPB = 16;
    localparam int TO  = 200;

    logic        CLK;
    logic        Reset;
    logic        Rx;
    logic [31:0] WriteData;
    logic        WriteStrobe;
    logic        ComActive;
    logic        ErrorFrame;

    int          n_chk;
    int          n_err;
    int          n_strb;
    int          n_ferr;
    int          cyc;
    logic        prev_stb;
    logic [31:0] exp_q[$];
    int          st_cyc[$];

    config_uart_rx #(
        .CLKS_PER_BIT  (CPB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Rx         (Rx),
        .WriteData  (WriteData),
        .WriteStrobe(WriteStrobe),
        .ComActive  (ComActive),
        .ErrorFrame (ErrorFrame)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic v);
        Rx = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        cyc++;
        if (WriteStrobe) begin
            n_strb++;
            st_cyc.push_back(cyc);
            check("stb_width", {31'd0, prev_stb}, 0);
            check("act_at_stb", {31'd0, ComActive}, 1);
            if (exp_q.size() > 0)
                check("wdata", WriteData, exp_q.pop_front());
            else
                check("sb_underflow", exp_q.size(), 1);
        end
        if (ErrorFrame) begin
            n_ferr++;
            check("err_with_stb", {31'd0, WriteStrobe}, 0);
        end
        prev_stb = WriteStrobe;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        n_strb = 0;
        n_ferr = 0;
        cyc = 0;
        prev_stb = 1'b0;
        Reset = 1'b1;
        Rx = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_wdata", WriteData, 0);
        check("rst_stb", {31'd0, WriteStrobe}, 0);
        check("rst_act", {31'd0, ComActive}, 0);
        check("rst_ferr", {31'd0, ErrorFrame}, 0);
        check("rst_state", 32'(dut.u_rx.state), 32'(RX_IDLE));
        check("rst_bcnt", 32'(dut.byte_cnt), 0);
        Reset = 1'b0;
        idle(4);

        // basic word
        exp_q.push_back(32'hFAB0FAB1);
        send_byte(8'hFA, 1'b1);
        check("act_after_b1", {31'd0, ComActive}, 1);
        send_byte(8'hB0, 1'b1);
        send_byte(8'hFA, 1'b1);
        send_byte(8'hB1, 1'b1);
        idle(2);
        check("basic_strobes", n_strb, 1);
        check("basic_ferr", n_ferr, 0);
        check("basic_stb_low", {31'd0, WriteStrobe}, 0);

        // glitch shorter than half a bit
        Rx = 1'b0;
        repeat (4) @(negedge CLK);
        idle(30);
        check("glitch_state", 32'(dut.u_rx.state), 32'(RX_IDLE));
        check("glitch_strobes", n_strb, 1);
        check("glitch_ferr", n_ferr, 0);
        check("glitch_act", {31'd0, ComActive}, 1);

        // framing error drops the partial word
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b0);
        idle(2 * CPB);
        check("frame_ferr", n_ferr, 1);
        check("frame_bcnt", 32'(dut.byte_cnt), 0);
        send_word(32'h01020304);
        idle(4);
        check("frame_strobes", n_strb, 2);

        // timeout mid-word
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        idle(TO + 50);
        check("tmo_act", {31'd0, ComActive}, 0);
        check("tmo_bcnt", 32'(dut.byte_cnt), 0);
        check("tmo_strobes", n_strb, 2);
        exp_q.push_back(32'hDEADBEEF);
        send_byte(8'hDE, 1'b1);
        check("tmo_reraise", {31'd0, ComActive}, 1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        idle(4);
        check("tmo_strobes2", n_strb, 3);

        // asynchronous reset during data bits of byte 2
        send_byte(8'h99, 1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        check("pre_rst_wdata", WriteData, 32'hDEADBEEF);
        #1 Reset = 1'b1;
        #1;
        check("arst_wdata", WriteData, 0);
        check("arst_act", {31'd0, ComActive}, 0);
        check("arst_stb", {31'd0, WriteStrobe}, 0);
        check("arst_ferr", {31'd0, ErrorFrame}, 0);
        check("arst_state", 32'(dut.u_rx.state), 32'(RX_IDLE));
        repeat (3) @(negedge CLK);
        Rx = 1'b1;
        Reset = 1'b0;
        idle(4);
        send_word(32'h12345678);
        idle(4);
        check("rst_strobes", n_strb, 4);

        // three words back-to-back
        st_cyc.delete();
        send_word(32'hCAFEF00D);
        send_word(32'h0BADC0DE);
        send_word(32'h80000001);
        idle(50);
        check("burst_count", st_cyc.size(), 3);
        if (st_cyc.size() == 3) begin
            check("burst_gap1", st_cyc[1] - st_cyc[0], 40 * CPB);
            check("burst_gap2", st_cyc[2] - st_cyc[1], 40 * CPB);
        end
        check("hold_wdata", WriteData, 32'h80000001);
        check("total_strobes", n_strb, 7);
        check("total_ferr", n_ferr, 1);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
